seq_divide: RTL

//  Multi-cycle signed/unsigned integer divider; inverse operation of the ALU multiply path.

---
 rtl/seq_divide.sv | 124 ++++++++++++
 1 files changed

// File: rtl/seq_divide.sv
// Multi-cycle non-restoring integer divider (signed or unsigned).
// Result is packed as {remainder, quotient}, the same HI:LO layout the multiplier uses.
module seq_divide #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic               clock,
  input  logic               clear_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] Result
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, ITER, FIX, ZERO} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             neg_dividend;
  logic             neg_divisor;

  logic             dividend_neg_in;
  logic             divisor_neg_in;
  logic [WIDTH-1:0] dividend_abs;
  logic [WIDTH-1:0] divisor_abs;
  logic [WIDTH:0]   dvs_ext;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] rem_fixed;
  logic [WIDTH-1:0] quo_final;
  logic [WIDTH-1:0] rem_final;

  // Magnitudes are unsigned WIDTH-bit values, so |most-negative| fits without overflow.
  always_comb begin
    dividend_neg_in = SIGNED && dividend[WIDTH-1];
    divisor_neg_in  = SIGNED && divisor[WIDTH-1];
    dividend_abs    = dividend_neg_in ? (~dividend + ONE) : dividend;
    divisor_abs     = divisor_neg_in  ? (~divisor  + ONE) : divisor;
  end

  // The W+1-bit partial remainder may wrap while shifting; the true value after
  // the add/subtract always fits, so modular arithmetic gives the right result.
  always_comb begin
    dvs_ext   = {1'b0, dvs};
    rem_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
    rem_step  = rem[WIDTH] ? (rem_shift + dvs_ext) : (rem_shift - dvs_ext);
    quo_step  = {quo[WIDTH-2:0], ~rem_step[WIDTH]};
    rem_fixed = rem[WIDTH] ? (rem[WIDTH-1:0] + dvs) : rem[WIDTH-1:0];
    quo_final = (neg_dividend ^ neg_divisor) ? (~quo + ONE) : quo;
    rem_final = neg_dividend ? (~rem_fixed + ONE) : rem_fixed;
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state        <= IDLE;
      count        <= '0;
      rem          <= '0;
      quo          <= '0;
      dvs          <= '0;
      neg_dividend <= 1'b0;
      neg_divisor  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      div_by_zero  <= 1'b0;
      Result       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy         <= 1'b1;
            count        <= '0;
            rem          <= '0;
            dvs          <= divisor_abs;
            neg_dividend <= dividend_neg_in;
            neg_divisor  <= divisor_neg_in;
            // The zero path reports the raw dividend, so keep it unmodified there.
            if (divisor == '0) begin
              quo   <= dividend;
              state <= ZERO;
            end else begin
              quo   <= dividend_abs;
              state <= ITER;
            end
          end
        end
        ITER: begin
          rem   <= rem_step;
          quo   <= quo_step;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          Result      <= {rem_final, quo_final};
          div_by_zero <= 1'b0;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        ZERO: begin
          Result      <= {quo, {WIDTH{1'b1}}};
          div_by_zero <= 1'b1;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
